// File: rtl/fft_stage_sequencer_if.sv
// Control/address bundle between the FFT stage sequencer (master) and its
// butterfly datapath plus host (slave).
interface fft_stage_sequencer_if #(
  parameter int FFT_N = 10
);
  localparam int SW = $clog2(FFT_N);

  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             bfly_iact;
  logic [1:0]       bfly_ictrl;
  logic [FFT_N-1:0] addr_a;
  logic [FFT_N-1:0] addr_b;
  logic [FFT_N-2:0] twiddle_addr;
  logic             bfly_oact;

  modport master (
    input  start, bfly_oact,
    output busy, done, stage, bfly_iact, bfly_ictrl, addr_a, addr_b, twiddle_addr
  );

  modport slave (
    output start, bfly_oact,
    input  busy, done, stage, bfly_iact, bfly_ictrl, addr_a, addr_b, twiddle_addr
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIF FFT stage sequencer: issues N/2 butterflies per stage and waits for writeback.
// Optional macro FFT_SEQ_CYCLE_COUNT_EN adds a 32-bit busy-cycle counter output.
module fft_stage_sequencer #(
  parameter int FFT_N        = 10,
  parameter int BFLY_LATENCY = 6
) (
  input  logic clk,
  input  logic reset,
  fft_stage_sequencer_if.master bus
`ifdef FFT_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0] cycle_count
`endif
);

  localparam int               SW         = $clog2(FFT_N);
  localparam int               KW         = FFT_N - 1;
  localparam logic [FFT_N-1:0] HALF       = FFT_N'(1 << (FFT_N - 1));
  localparam logic [KW-1:0]    K_LAST     = '1;
  localparam logic [SW-1:0]    LAST_STAGE = SW'(FFT_N - 1);
  localparam logic [FFT_N-1:0] ONE_A      = FFT_N'(1);

  // Completion is tracked by counting writebacks, so the latency value only documents the datapath.
  if (BFLY_LATENCY < 0) begin : g_negative_latency
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [KW-1:0]    k_q, k_d;
  logic [FFT_N-1:0] cnt_q, cnt_d, cnt_inc;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             iact_q, iact_d;
  logic [1:0]       ictrl_q, ictrl_d;
  logic [FFT_N-1:0] addr_a_q, addr_a_d;
  logic [FFT_N-1:0] addr_b_q, addr_b_d;
  logic [KW-1:0]    tw_q, tw_d;
  logic [FFT_N-1:0] low_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      iact_q   <= 1'b0;
      ictrl_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      iact_q   <= iact_d;
      ictrl_q  <= ictrl_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
    end
  end

  // Outputs are computed from the next-cycle butterfly index so they leave the flops aligned with bfly_iact.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    iact_d   = 1'b0;
    cnt_d    = cnt_q;
    cnt_inc  = (bus.bfly_oact && (cnt_q != HALF)) ? cnt_q + ONE_A : cnt_q;
    addr_a_d = '0;
    addr_b_d = '0;
    tw_d     = '0;
    ictrl_d  = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          stage_d = '0;
          k_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          iact_d  = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d = cnt_inc;
        if (k_q == K_LAST) begin
          state_d = DRAIN;
        end else begin
          k_d    = k_q + KW'(1);
          iact_d = 1'b1;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (cnt_inc == HALF) begin
          if (stage_q == LAST_STAGE) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
            cnt_d   = '0;
            iact_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // low_mask has FFT_N-1-stage ones: the bits of k below the inserted zero, and span-1.
    low_mask = {FFT_N{1'b1}} >> (int'(stage_d) + 1);
    if (iact_d) begin
      addr_a_d = (({1'b0, k_d} & ~low_mask) << 1) | ({1'b0, k_d} & low_mask);
      addr_b_d = addr_a_d + low_mask + ONE_A;
      tw_d     = (k_d & low_mask[KW-1:0]) << stage_d;
      ictrl_d  = {k_d == K_LAST, k_d == '0};
    end
  end

`ifdef FFT_SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      cycle_count <= '0;
    end else if (busy_q) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.stage        = stage_q;
  assign bus.bfly_iact    = iact_q;
  assign bus.bfly_ictrl   = ictrl_q;
  assign bus.addr_a       = addr_a_q;
  assign bus.addr_b       = addr_b_q;
  assign bus.twiddle_addr = tw_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer (FFT_N=3): random butterfly latency, stray starts/writebacks, mid-run reset.
module tb_fft_stage_sequencer;

  localparam int FFT_N  = 3;
  localparam int N      = 8;
  localparam int HALF   = N / 2;
  localparam int STAGES = FFT_N;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fft_stage_sequencer_if #(.FFT_N(FFT_N)) bus ();

`ifdef FFT_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  fft_stage_sequencer #(
    .FFT_N        (FFT_N),
    .BFLY_LATENCY (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int stage;
    int a;
    int b;
    int tw;
    int ictrl;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pend[$];
  int   cyc           = 0;
  int   n_checks      = 0;
  int   n_pass        = 0;
  int   lat           = 6;
  bit   extra_en      = 1'b0;
  bit   stray_en      = 1'b0;
  int   wb_cnt        = 0;
  int   full_cyc      = -10;
  int   last_iact_cyc = -10;
  int   st_cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic checkIdleOutputs();
    checkOutput("rst_busy",   int'(bus.busy), 0);
    checkOutput("rst_done",   int'(bus.done), 0);
    checkOutput("rst_iact",   int'(bus.bfly_iact), 0);
    checkOutput("rst_ictrl",  int'(bus.bfly_ictrl), 0);
    checkOutput("rst_stage",  int'(bus.stage), 0);
    checkOutput("rst_addr_a", int'(bus.addr_a), 0);
    checkOutput("rst_addr_b", int'(bus.addr_b), 0);
    checkOutput("rst_twid",   int'(bus.twiddle_addr), 0);
  endtask

  // Reference sequence: each stage splits the array into blocks of 2*span and pairs i with i+span.
  task automatic pushExpected(input int start_cycle);
    exp_t e;
    int   k;
    for (int s = 0; s < STAGES; s++) begin
      int span = N >> (s + 1);
      k = 0;
      for (int blk = 0; blk < N; blk += 2 * span) begin
        for (int i = 0; i < span; i++) begin
          e.is_done = 1'b0;
          e.stage   = s;
          e.a       = blk + i;
          e.b       = blk + i + span;
          e.tw      = i << s;
          e.ictrl   = ((k == 0) ? 1 : 0) | ((k == HALF - 1) ? 2 : 0);
          e.cyc     = (s == 0 && k == 0) ? start_cycle + 1 : -1;
          exp_q.push_back(e);
          k++;
        end
      end
    end
    e = '{is_done: 1'b1, stage: 0, a: 0, b: 0, tw: 0, ictrl: 0, cyc: -1};
    exp_q.push_back(e);
  endtask

  // Butterfly model: each issue returns a writeback lat cycles later; optional extra or stray pulses.
  always @(negedge clk) begin : drv
    bit emit;
    emit = 1'b0;
    if (bus.bfly_iact) begin
      if (bus.bfly_ictrl[0]) wb_cnt = 0;
      pend.push_back(cyc + lat);
    end
    if (pend.size() > 0 && pend[0] <= cyc) begin
      void'(pend.pop_front());
      emit = 1'b1;
      if (wb_cnt < HALF) begin
        wb_cnt++;
        if (wb_cnt == HALF) full_cyc = cyc;
      end
    end else if (extra_en && lat == 0 && cyc == full_cyc + 1) begin
      emit = 1'b1;
    end else if (stray_en) begin
      emit = ($urandom_range(0, 1) == 1);
    end
    bus.bfly_oact = emit;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    int   exp_c;
    if (!reset && (bus.bfly_iact || bus.done)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", int'({bus.bfly_iact, bus.done}), 0);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc >= 0)
          exp_c = e.cyc;
        else if (e.is_done || (e.ictrl & 1) != 0)
          exp_c = ((full_cyc > last_iact_cyc + 1) ? full_cyc : last_iact_cyc + 1) + 1;
        else
          exp_c = last_iact_cyc + 1;
        checkOutput("out_is_done", int'(bus.done), int'(e.is_done));
        checkOutput(e.is_done ? "done_cycle" : "iact_cycle", cyc, exp_c);
        checkOutput("busy", int'(bus.busy), e.is_done ? 0 : 1);
        if (!e.is_done) begin
          checkOutput("stage",   int'(bus.stage), e.stage);
          checkOutput("addr_a",  int'(bus.addr_a), e.a);
          checkOutput("addr_b",  int'(bus.addr_b), e.b);
          checkOutput("twiddle", int'(bus.twiddle_addr), e.tw);
          checkOutput("ictrl",   int'(bus.bfly_ictrl), e.ictrl);
          last_iact_cyc = cyc;
        end else begin
          checkOutput("iact_in_done", int'(bus.bfly_iact), 0);
`ifdef FFT_SEQ_CYCLE_COUNT_EN
          checkOutput("cycle_count", int'(cycle_count), cyc - st_cyc - 1);
`endif
        end
      end
    end
  end

  task automatic applyStimulus(input int l, input bit ex, input bit rst_mid);
    bit finished;
    lat      = l;
    extra_en = ex;
    @(negedge clk);
    stray_en = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    st_cyc    = cyc;
    pushExpected(cyc);
    @(negedge clk);
    bus.start = 1'b0;
    finished  = 1'b0;
    for (int budget = 0; budget < 300 && !finished; budget++) begin
      @(negedge clk);
      if (bus.done) begin
        finished = 1'b1;
      end else if (rst_mid && bus.busy && int'(bus.stage) == 1 && !bus.bfly_iact) begin
        reset     = 1'b1;
        bus.start = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        checkIdleOutputs();
        finished = 1'b1;
      end else begin
        bus.start = ($urandom_range(0, 3) == 0);
      end
    end
    if (!finished) begin
      checkOutput("done_timeout", int'(bus.done), 1);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
    end else if (!rst_mid) begin
      bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    stray_en  = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("idle_busy", int'(bus.busy), 0);
    extra_en = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs();
    $display("[TB] nominal run, latency 6");
    applyStimulus(6, 1'b0, 1'b0);
    $display("[TB] zero latency with extra writeback pulse");
    applyStimulus(0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      int l = $urandom_range(1, 7);
      $display("[TB] random latency %0d", l);
      applyStimulus(l, 1'b0, 1'b0);
    end
    $display("[TB] reset during stage 1 drain");
    applyStimulus($urandom_range(1, 7), 1'b0, 1'b1);
    applyStimulus(6, 1'b0, 1'b0);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter FFT_N, default 10, log2 of FFT point count (N = 2^FFT_N).
REQ-002 SHALL have parameter BFLY_LATENCY, default 6, butterfly iact-to-oact latency in cycles (informational; completion is tracked by counting bfly_oact).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to run a full FFT.
REQ-006 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the final stage has fully written back.
REQ-008 SHALL have port stage  output  $clog2(FFT_N)  current stage index.
REQ-009 SHALL have port bfly_iact  output  1  butterfly issue strobe.
REQ-010 SHALL have port bfly_ictrl  output  2  bit0 = first butterfly of stage; bit1 = last butterfly of stage.
REQ-011 SHALL have port addr_a  output  FFT_N  memory address of operand A.
REQ-012 SHALL have port addr_b  output  FFT_N  memory address of operand B.
REQ-013 SHALL have port twiddle_addr  output  FFT_N-1  twiddle ROM index.
REQ-014 SHALL have port bfly_oact  input  1  butterfly writeback strobe.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL move to ISSUE with stage=0 and butterfly index k=0; start SHALL be ignored in all other states.
REQ-017 ISSUE: SHALL assert bfly_iact for exactly N/2 consecutive cycles, k incrementing 0..N/2-1, one butterfly per cycle.
REQ-018 Addressing (DIF), span = N >> (stage+1): addr_a = k with a 0 bit inserted at bit position FFT_N-1-stage; addr_b = addr_a + span; twiddle_addr = (k mod span) << stage.
REQ-019 bfly_ictrl bit0 SHALL be high only when k=0, bit1 only when k=N/2-1; both low when bfly_iact is low.
REQ-020 All outputs SHALL be registered; address, twiddle_addr and ictrl SHALL be valid in the same cycle as bfly_iact.
REQ-021 After issuing k=N/2-1, SHALL enter DRAIN.
REQ-022 A writeback counter SHALL count bfly_oact pulses in ISSUE and DRAIN.
REQ-023 The writeback counter SHALL clear on entry to each stage.
REQ-024 bfly_oact SHALL be ignored in IDLE and DONE.
REQ-025 DRAIN: when the count reaches N/2 and stage < FFT_N-1, SHALL increment stage, clear k and the counter, and return to ISSUE next cycle.
REQ-026 DRAIN: when the count reaches N/2 and stage = FFT_N-1, SHALL enter DONE.
REQ-027 The last bfly_oact and the count update SHALL be evaluated in the same cycle; no extra dead cycle is permitted.
REQ-028 DONE: SHALL assert done for one cycle, deassert busy, and return to IDLE.
REQ-029 A start arriving in the DONE cycle SHALL be ignored.
REQ-030 The counter SHALL saturate at N/2; extra bfly_oact pulses SHALL be ignored.
REQ-031 No bfly_iact SHALL be issued in DRAIN, so in-place stage data never overlaps.

Reset
REQ-032 reset SHALL override all other inputs, including mid-operation, and return to IDLE on the next clock edge.
REQ-033 After reset: busy=0, done=0, bfly_iact=0, bfly_ictrl=0, stage=0, addr_a=0, addr_b=0, twiddle_addr=0, k=0, counter=0.
REQ-034 Butterflies in flight at reset SHALL be discarded; their bfly_oact pulses are ignored in IDLE.

Configuration
REQ-035 Macro FFT_SEQ_CYCLE_COUNT_EN defined: SHALL add output cycle_count[31:0]; it clears when start is accepted, increments each cycle busy=1, holds its value after done, and is reset to 0 by reset.
REQ-036 Macro FFT_SEQ_CYCLE_COUNT_EN undefined: cycle_count port and logic SHALL be absent, with all other behaviour identical.

Verification (FFT_N=3, N=8, bfly_oact = bfly_iact delayed 6 cycles)
REQ-037 Stage 0: start -> (addr_a,addr_b,twiddle_addr) = (0,4,0),(1,5,1),(2,6,2),(3,7,3); ictrl = 01,00,00,10.
REQ-038 Stage 1 -> (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2 -> (0,1,0),(2,3,0),(4,5,0),(6,7,0).
REQ-039 Each stage's first bfly_iact SHALL occur the cycle after the 4th bfly_oact of the previous stage.
REQ-040 done SHALL pulse once, one cycle after the final 4th bfly_oact; busy SHALL then be 0.
REQ-041 start pulsed during ISSUE of stage 1 -> no effect on the sequence; reset asserted in stage 1 DRAIN -> IDLE next cycle with all outputs 0, and later stray bfly_oact causes no state change.
REQ-042 With FFT_SEQ_CYCLE_COUNT_EN, a bfly_oact burst of 10 extra pulses in DRAIN -> counter saturates, no early advance; cycle_count equals the busy-cycle total and holds after done.
